seq_shift_add_multiplier: RTL and testbench
===========================================

Name: seq_shift_add_multiplier

Overview:
Parametrised sequential shift-add multiplier with an integrated controller. It generalises the fixed 4-bit HI/LO datapath to WIDTH-bit operands and adds a start/ready request handshake and a valid/ready result handshake. It sits between the ALU issue logic and writeback as a multi-cycle functional unit. An optional signed mode is compiled in by macro.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits; legal range 2..32
CNT_W, $clog2(WIDTH+1), width of the step counter; localparam, not overridable

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous active-low reset
start  input  1  request; accepted on an edge where start=1 and start_ready=1
multiplicand  input  WIDTH  operand A; sampled only at acceptance
multiplier  input  WIDTH  operand B; sampled only at acceptance
signed_op  input  1  treat operands as two's complement; sampled at acceptance; ignored unless SIGNED_MODE_EN
abort  input  1  synchronous cancel of an in-flight operation
start_ready  output  1  high only in IDLE
busy  output  1  high in CALC and FIX
result_valid  output  1  high only in DONE
result_ready  input  1  consumer accepts product when result_valid=1
product  output  2*WIDTH  {HI,LO}; stable while result_valid=1

Behaviour:
- Reset (reset=0 at an edge): state=IDLE; HI, LO, MCAND, count, neg flag = 0; product=0, start_ready=1, busy=0, result_valid=0. Reset overrides everything, including mid-operation.
- States: IDLE, CALC, FIX (exists only with the macro), DONE.
- IDLE, start=1: load HI=0, LO=multiplier, MCAND=multiplicand, count=WIDTH; go to CALC. Otherwise stay in IDLE.
- CALC, each edge:
  - If LO[0]=1: {HI,LO} <= {cout, HI+MCAND, LO[WIDTH-1:1]}, where the add is WIDTH+1 bits wide and cout becomes the new MSB.
  - Else: {HI,LO} <= {1'b0, HI, LO[WIDTH-1:1]}.
  - count decrements by 1.
  - The edge with count=1 moves to DONE, or to FIX if neg=1.
- FIX: {HI,LO} <= two's-complement negation of {HI,LO}; go to DONE.
- DONE: result_valid=1 and product={HI,LO}. Hold until result_ready=1 at an edge, then go to IDLE.
- Latency: start accepted at edge 0, result_valid visible after edge WIDTH (unsigned) or edge WIDTH+1 (signed and negative).
- Throughput: at most one operation per WIDTH+2 cycles. A new start is not accepted in the DONE-exit cycle; start_ready rises one cycle later.
- abort=1 in CALC or FIX: go to IDLE next edge, no result produced, registers keep their values. abort is ignored in IDLE and DONE. Reset has priority over abort.
- Operand changes after acceptance have no effect.
- start asserted while not in IDLE is ignored, not queued.
- Edge values are exact:
  - Zero operands produce 0 after the full WIDTH steps; there is no early termination.
  - (2^WIDTH-1)^2 must not overflow.

Optional Feature:
SIGNED_MODE_EN.
- Defined: at acceptance with signed_op=1, MCAND and LO load the absolute values of the operands, and neg = sign(A) XOR sign(B). FIX negates the result when neg=1.
  - Most-negative operand: the absolute value of -2^(WIDTH-1) is loaded as the unsigned magnitude 2^(WIDTH-1); the result must be correct.
- Undefined: signed_op is ignored, neg is always 0, the FIX state and its logic are absent, and all operands are unsigned.

Test Plan:
- WIDTH=8, A=13, B=11, result_ready=1 → result_valid rises 8 cycles after acceptance; product=16'd143; next start accepted 2 cycles after DONE.
- A=255, B=255 → product=16'hFE01; carry path exercised on every step.
- A=0, B=200, then A=200, B=0 → product=0 both times; each takes the full 8 cycles.
- result_ready held low for 5 cycles in DONE while start pulses → product stable and start ignored; release ready → IDLE, then accept.
- reset=0 asserted at step 4, then abort asserted at step 4 of a new operation → both return to IDLE with result_valid never asserted. After the reset case, all outputs are at their reset values.
- With SIGNED_MODE_EN, signed_op=1:
  - -3 × 5 → product=16'hFFF1 after 9 cycles.
  - -128 × -128 → 16'h4000.
  - 7 × 6 → 16'd42 after 8 cycles.

Source files
------------

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier with start/ready request and valid/ready result handshakes.
// WIDTH-bit operands, 2*WIDTH-bit product {HI,LO}, one add/shift step per clock.
// Optional signed mode (magnitude multiply plus final negation) is enabled by defining SIGNED_MODE_EN.
module seq_shift_add_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               signed_op,
  input  logic               abort,
  output logic               start_ready,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

`ifdef SIGNED_MODE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hi, lo, mcand;
  logic [WIDTH-1:0] hi_nxt, lo_nxt, mcand_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] a_load_c, b_load_c;

`ifdef SIGNED_MODE_EN
  logic neg, neg_nxt, neg_load_c;

  // Signed requests load operand magnitudes; -2^(WIDTH-1) maps onto its own bit pattern as an unsigned magnitude.
  always_comb begin
    a_load_c   = multiplicand;
    b_load_c   = multiplier;
    neg_load_c = 1'b0;
    if (signed_op) begin
      if (multiplicand[WIDTH-1]) a_load_c = WIDTH'(-multiplicand);
      if (multiplier[WIDTH-1])   b_load_c = WIDTH'(-multiplier);
      neg_load_c = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
    end
  end
`else
  logic unused_signed_op;

  // Unsigned-only build: operands pass straight through, signed_op has no effect.
  assign a_load_c         = multiplicand;
  assign b_load_c         = multiplier;
  assign unused_signed_op = signed_op;
`endif

  // WIDTH+1-bit partial-sum adder; the carry becomes the new HI MSB.
  assign sum_c = {1'b0, hi} + {1'b0, mcand};

  // Product is the HI/LO register pair itself.
  assign product = {hi, lo};

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    hi_nxt    = hi;
    lo_nxt    = lo;
    mcand_nxt = mcand;
    count_nxt = count;
`ifdef SIGNED_MODE_EN
    neg_nxt   = neg;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          hi_nxt    = '0;
          lo_nxt    = b_load_c;
          mcand_nxt = a_load_c;
          count_nxt = CNT_W'(WIDTH);
`ifdef SIGNED_MODE_EN
          neg_nxt   = neg_load_c;
`endif
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          if (lo[0]) {hi_nxt, lo_nxt} = {sum_c, lo[WIDTH-1:1]};
          else       {hi_nxt, lo_nxt} = {1'b0, hi, lo[WIDTH-1:1]};
          count_nxt = count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
`ifdef SIGNED_MODE_EN
            state_nxt = neg ? FIX : DONE;
`else
            state_nxt = DONE;
`endif
          end
        end
      end
`ifdef SIGNED_MODE_EN
      FIX: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          {hi_nxt, lo_nxt} = (2*WIDTH)'(-{hi, lo});
          state_nxt        = DONE;
        end
      end
`endif
      DONE: begin
        if (result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      hi           <= '0;
      lo           <= '0;
      mcand        <= '0;
      count        <= '0;
`ifdef SIGNED_MODE_EN
      neg          <= 1'b0;
`endif
      start_ready  <= 1'b1;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      hi           <= hi_nxt;
      lo           <= lo_nxt;
      mcand        <= mcand_nxt;
      count        <= count_nxt;
`ifdef SIGNED_MODE_EN
      neg          <= neg_nxt;
      busy         <= (state_nxt == CALC) || (state_nxt == FIX);
`else
      busy         <= (state_nxt == CALC);
`endif
      start_ready  <= (state_nxt == IDLE);
      result_valid <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier (WIDTH=8): driver pushes expected results, monitor checks them.
module tb_seq_shift_add_multiplier;

  localparam int unsigned W = 8;
`ifdef SIGNED_MODE_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset, start, signed_op, abort, result_ready;
  logic           start_ready, busy, result_valid;
  logic [W-1:0]   multiplicand, multiplier;
  logic [2*W-1:0] product;

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .multiplicand(multiplicand),
    .multiplier(multiplier), .signed_op(signed_op), .abort(abort),
    .start_ready(start_ready), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready), .product(product)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2*W-1:0] prod;
    int             lat;
    int             acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   rand_ready = 1'b0;
  bit   ready_force = 1'b1;
  bit   prev_v = 1'b0;
  logic [2*W-1:0] cur;
  exp_t mon_e;

  always @(posedge clock) cyc++;

  // Single driver of result_ready: forced level or random per cycle.
  always @(negedge clock) result_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Reference: plain integer multiply; signed requests add one cycle when signs differ.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int acc);
    longint pa, pb;
    exp_t   e;
    pa = longint'(a);
    pb = longint'(b);
    e.lat = W;
    if (SGN_EN && s) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      if ((pa < 0) != (pb < 0)) e.lat = W + 1;
    end
    e.prod = (2*W)'(pa * pb);
    e.acc  = acc;
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit push);
    int n;
    n = 0;
    @(negedge clock);
    while (!start_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!start_ready) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: start_ready got %0b want 1", start_ready);
      return;
    end
    start = 1'b1; multiplicand = a; multiplier = b; signed_op = s;
    @(posedge clock);
    #1;
    start = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
    signed_op    = 1'($urandom_range(0, 1));
    if (push) q.push_back(model(a, b, s, cyc));
  endtask

  // Counts negedges until start_ready returns, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!start_ready && n < 200);
  endtask

  // Monitor: compare on each new result, and check product holds while valid.
  always @(negedge clock) begin
    if (mon_en) begin
      if (result_valid && !prev_v) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got product %0h want no result", product);
        end else begin
          mon_e = q.pop_front();
          chk("product", 64'(product), 64'(mon_e.prod));
          chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
          cur = mon_e.prod;
        end
      end else if (result_valid) begin
        chk("product_hold", 64'(product), 64'(cur));
      end
      prev_v = result_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; abort = 1'b0; signed_op = 1'b0;
    multiplicand = '0; multiplier = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_start_ready", 64'(start_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(result_valid), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    reset = 1'b1;
    mon_en = 1'b1;

    // 13 x 11 with ready high: start_ready back W+2 negedges after acceptance.
    ready_force = 1'b1;
    issue(8'd13, 8'd11, 1'b0, 1'b1);
    @(negedge clock);
    chk("busy_after_accept", 64'(busy), 64'd1);
    chk("start_ready_busy", 64'(start_ready), 64'd0);
    n = 1;
    while (!start_ready && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("throughput", 64'(n), 64'(W + 2));

    issue(8'd255, 8'd255, 1'b0, 1'b1);
    issue(8'd0, 8'd200, 1'b0, 1'b1);
    issue(8'd200, 8'd0, 1'b0, 1'b1);
    wait_idle(n);

    // Result held with ready low; start pulses must be ignored.
    ready_force = 1'b0;
    repeat (2) @(negedge clock);
    issue(8'd37, 8'd91, 1'b0, 1'b1);
    n = 0;
    while (!result_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("hold_reached_done", 64'(result_valid), 64'd1);
    repeat (5) begin
      start = 1'b1; multiplicand = W'($urandom); multiplier = W'($urandom);
      @(negedge clock);
      chk("hold_valid", 64'(result_valid), 64'd1);
      chk("hold_no_accept", 64'(start_ready), 64'd0);
    end
    start = 1'b0;
    ready_force = 1'b1;
    wait_idle(n);
    chk("hold_release", 64'(start_ready), 64'd1);
    issue(8'd5, 8'd6, 1'b0, 1'b1);
    wait_idle(n);

    // Reset mid-operation: back to reset values, no result.
    issue(8'd100, 8'd100, 1'b0, 1'b0);
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("midrst_start_ready", 64'(start_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_valid", 64'(result_valid), 64'd0);
    chk("midrst_product", 64'(product), 64'd0);
    reset = 1'b1;

    // Abort mid-operation: back to IDLE, no result.
    issue(8'd100, 8'd100, 1'b0, 1'b0);
    repeat (4) @(negedge clock);
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    chk("abort_start_ready", 64'(start_ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (12) @(negedge clock);
    chk("abort_no_valid", 64'(result_valid), 64'd0);
    issue(8'd9, 8'd9, 1'b0, 1'b1);
    wait_idle(n);

`ifdef SIGNED_MODE_EN
    issue(8'hFD, 8'd5, 1'b1, 1'b1);
    issue(8'h80, 8'h80, 1'b1, 1'b1);
    issue(8'd7, 8'd6, 1'b1, 1'b1);
    issue(8'h80, 8'd1, 1'b1, 1'b1);
    issue(8'hFD, 8'd0, 1'b1, 1'b1);
    issue(8'hFD, 8'd5, 1'b0, 1'b1);
    wait_idle(n);
`endif

    // Random operands, sign request and consumer back-pressure.
    rand_ready = 1'b1;
    repeat (30) issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    rand_ready = 1'b0;
    ready_force = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk("queue_drained", 64'(q.size()), 64'd0);
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
